// File: rtl/sec_lvl_initiator.sv
// Security-level register initiator: writes the requested level to a bus
// target, optionally reads it back, and retries on timeout or mismatch.
module sec_lvl_initiator #(
    parameter logic [31:0] TARGET_ADDR    = 32'h0,
    parameter int          TIMEOUT_CYCLES = 16,
    parameter int          MAX_RETRIES    = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_level_i,
    input  logic        cmd_verify_i,
    output logic        done_o,
    output logic        err_o,
    output logic        level_o,
    output logic        req_o,
    output logic        we_o,
    output logic [3:0]  be_o,
    output logic [31:0] addr_o,
    output logic        wdata_o,
    input  logic        rvalid_i,
    input  logic        rdata_i
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_REQ,
        S_WR_WAIT,
        S_RD_REQ,
        S_RD_WAIT
    } state_t;

    state_t          r_state;
    logic            r_lvl;
    logic            r_ver;
    logic [RW-1:0]   r_retry;
    logic [TW-1:0]   r_wcnt;
    logic            r_req;
    logic            r_we;
    logic [3:0]      r_be;
    logic            r_wdata;
    logic            r_done;
    logic            r_err;
    logic            r_level;

    logic            w_wait;
    logic            w_tmo;
    logic            w_ok;
    logic            w_fail;
    logic            w_to_rd;
    logic            w_can_retry;

    // A response in the timeout cycle takes priority over the timeout.
    always_comb begin
        w_wait      = (r_state == S_WR_WAIT) || (r_state == S_RD_WAIT);
        w_tmo       = w_wait && !rvalid_i && (r_wcnt == TW'(TIMEOUT_CYCLES));
        w_ok        = ((r_state == S_WR_WAIT) && rvalid_i && !r_ver) ||
                      ((r_state == S_RD_WAIT) && rvalid_i && (rdata_i == r_lvl));
        w_fail      = w_tmo ||
                      ((r_state == S_RD_WAIT) && rvalid_i && (rdata_i != r_lvl));
        w_to_rd     = (r_state == S_WR_WAIT) && rvalid_i && r_ver;
        w_can_retry = (r_retry < RW'(MAX_RETRIES));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_lvl   <= 1'b0;
            r_ver   <= 1'b0;
            r_retry <= '0;
            r_wcnt  <= '0;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_be    <= 4'b0000;
            r_wdata <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_level <= 1'b0;
        end else begin
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_be    <= 4'b0000;
            r_wdata <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            if (r_state == S_IDLE) begin
                if (cmd_valid_i) begin
                    r_lvl   <= cmd_level_i;
                    r_ver   <= cmd_verify_i;
                    r_retry <= '0;
                    r_state <= S_WR_REQ;
                    r_req   <= 1'b1;
                    r_we    <= 1'b1;
                    r_be    <= 4'b0001;
                    r_wdata <= cmd_level_i;
                end
            end else if (w_ok) begin
                r_state <= S_IDLE;
                r_done  <= 1'b1;
                r_level <= r_lvl;
            end else if (w_fail) begin
                if (w_can_retry) begin
                    r_retry <= r_retry + 1'b1;
                    r_state <= S_WR_REQ;
                    r_req   <= 1'b1;
                    r_we    <= 1'b1;
                    r_be    <= 4'b0001;
                    r_wdata <= r_lvl;
                end else begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b1;
                    r_err   <= 1'b1;
                end
            end else if (w_to_rd) begin
                r_state <= S_RD_REQ;
                r_req   <= 1'b1;
                r_be    <= 4'b0001;
            end else begin
                unique case (r_state)
                    S_WR_REQ: begin
                        r_state <= S_WR_WAIT;
                        r_wcnt  <= '0;
                    end
                    S_RD_REQ: begin
                        r_state <= S_RD_WAIT;
                        r_wcnt  <= '0;
                    end
                    S_WR_WAIT, S_RD_WAIT: r_wcnt <= r_wcnt + 1'b1;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign cmd_ready_o = (r_state == S_IDLE);
    assign done_o      = r_done;
    assign err_o       = r_err;
    assign level_o     = r_level;
    assign req_o       = r_req;
    assign we_o        = r_we;
    assign be_o        = r_be;
    assign addr_o      = TARGET_ADDR;
    assign wdata_o     = r_wdata;

endmodule

// File: tb/tb_sec_lvl_initiator.sv
// Scoreboard bench for sec_lvl_initiator with a mock one-cycle responder.
module tb_sec_lvl_initiator;

    localparam logic [31:0] TA = 32'hA000_0010;
    localparam int TO = 4;
    localparam int MR = 2;
    localparam int M_NORM  = 0;
    localparam int M_STUCK = 1;
    localparam int M_NONE  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_level = 1'b0;
    logic        cmd_verify = 1'b0;
    logic        rvalid = 1'b0;
    logic        rdata = 1'b0;
    logic        cmd_ready_o, done_o, err_o, level_o, req_o, we_o, wdata_o;
    logic [3:0]  be_o;
    logic [31:0] addr_o;

    sec_lvl_initiator #(
        .TARGET_ADDR(TA),
        .TIMEOUT_CYCLES(TO),
        .MAX_RETRIES(MR)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .cmd_valid_i(cmd_valid),
        .cmd_ready_o(cmd_ready_o),
        .cmd_level_i(cmd_level),
        .cmd_verify_i(cmd_verify),
        .done_o(done_o),
        .err_o(err_o),
        .level_o(level_o),
        .req_o(req_o),
        .we_o(we_o),
        .be_o(be_o),
        .addr_o(addr_o),
        .wdata_o(wdata_o),
        .rvalid_i(rvalid),
        .rdata_i(rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic lvl; logic ver; int mode;
        int att; int per; int dn; logic err; logic lvo;
    } vec_t;
    typedef struct { logic we; logic wd; int cyc; } bus_t;
    typedef struct { logic err; logic lvo; int cyc; } dn_t;

    vec_t vt[10];
    bus_t bq[$];
    dn_t  dq[$];
    int   cyc = 0;
    int   busy_until = 0;
    int   total = 0;
    int   bad = 0;
    int   acc_cnt = 0;
    int   wr_seen = 0;
    int   vi = 0;
    int   mode = M_NORM;
    logic stray = 1'b0;
    logic pend = 1'b0;
    logic mem = 1'b0;

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Predictor: pushes expected bus transactions and completion per accept.
    always @(posedge clk) begin : pred
        vec_t v;
        if (!rst && cmd_valid && cyc >= busy_until) begin
            v = vt[vi];
            for (int k = 0; k < v.att; k++) begin
                bq.push_back('{we: 1'b1, wd: v.lvl, cyc: cyc + 1 + k * v.per});
                if (v.ver)
                    bq.push_back('{we: 1'b0, wd: 1'b0, cyc: cyc + 3 + k * v.per});
            end
            dq.push_back('{err: v.err, lvo: v.lvo, cyc: cyc + v.dn});
            busy_until = cyc + v.dn;
            acc_cnt++;
        end
        cyc++;
    end

    // Monitor: pops and compares whenever the DUT presents req_o or done_o.
    always @(negedge clk) begin : mon
        bus_t b;
        dn_t  d;
        if (!rst) begin
            check("ready", {31'd0, cmd_ready_o}, {31'd0, cyc >= busy_until});
            if (req_o) begin
                if (we_o) wr_seen++;
                if (bq.size() == 0) begin
                    check("unexpected_req", 32'd1, 32'd0);
                end else begin
                    b = bq.pop_front();
                    check("req_we", {31'd0, we_o}, {31'd0, b.we});
                    check("req_wdata", {31'd0, wdata_o}, {31'd0, b.wd});
                    check("req_be", {28'd0, be_o}, 32'h1);
                    check("req_addr", addr_o, TA);
                    check("req_cycle", cyc, b.cyc);
                end
            end else begin
                check("idle_bus", {26'd0, we_o, be_o, wdata_o}, 32'd0);
            end
            if (done_o) begin
                if (dq.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    d = dq.pop_front();
                    check("done_err", {31'd0, err_o}, {31'd0, d.err});
                    check("done_level", {31'd0, level_o}, {31'd0, d.lvo});
                    check("done_cycle", cyc, d.cyc);
                end
            end else begin
                check("err_without_done", {31'd0, err_o}, 32'd0);
            end
        end
    end

    // Mock responder: answers one cycle after each request.
    always @(negedge clk) begin
        pend = req_o && !rst;
        if (req_o && we_o) mem = wdata_o;
    end

    always @(posedge clk) begin
        #1;
        rvalid = (pend && mode != M_NONE) || stray;
        rdata  = (mode == M_STUCK) ? 1'b0 : mem;
    end

    task automatic issue(int i);
        int n;
        int k;
        vi = i;
        mode = vt[i].mode;
        cmd_level = vt[i].lvl;
        cmd_verify = vt[i].ver;
        cmd_valid = 1'b1;
        n = acc_cnt;
        k = 0;
        while (acc_cnt == n && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        cmd_valid = 1'b0;
        check("accept_timeout", {31'd0, k >= 50}, 32'd0);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((dq.size() != 0 || bq.size() != 0) && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        check("drain_timeout", {31'd0, k >= 100}, 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int w0;
        //         lvl   ver   mode     att per dn  err   lvo
        vt[0] = '{1'b1, 1'b0, M_NORM,  1, 4, 3,  1'b0, 1'b1};
        vt[1] = '{1'b0, 1'b1, M_NORM,  1, 4, 5,  1'b0, 1'b0};
        vt[2] = '{1'b1, 1'b1, M_NORM,  1, 4, 5,  1'b0, 1'b1};
        vt[3] = '{1'b0, 1'b1, M_STUCK, 1, 4, 5,  1'b0, 1'b0};
        vt[4] = '{1'b1, 1'b1, M_STUCK, 3, 4, 13, 1'b1, 1'b0};
        vt[5] = '{1'b1, 1'b0, M_NONE,  3, 6, 19, 1'b1, 1'b0};
        vt[6] = '{1'b1, 1'b0, M_NORM,  1, 4, 3,  1'b0, 1'b1};
        vt[7] = '{1'b1, 1'b0, M_NONE,  3, 6, 19, 1'b1, 1'b1};
        vt[8] = '{1'b1, 1'b1, M_NORM,  1, 4, 5,  1'b0, 1'b1};
        vt[9] = '{1'b0, 1'b0, M_NORM,  1, 4, 3,  1'b0, 1'b0};

        #1 rst = 1'b1;
        #1;
        check("rst_bus", {26'd0, req_o, we_o, be_o, wdata_o}, 32'd0);
        check("rst_flags", {29'd0, done_o, err_o, level_o}, 32'd0);
        check("rst_ready", {31'd0, cmd_ready_o}, 32'd1);
        check("rst_addr", addr_o, TA);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i <= 6; i++) begin
            issue(i);
            wait_idle();
        end

        // Abort a write while waiting for its response.
        issue(7);
        @(posedge clk); #1;
        rst = 1'b1;
        bq.delete();
        dq.delete();
        busy_until = 0;
        #1;
        check("abort_req", {31'd0, req_o}, 32'd0);
        check("abort_done", {31'd0, done_o}, 32'd0);
        check("abort_ready", {31'd0, cmd_ready_o}, 32'd1);
        check("abort_level", {31'd0, level_o}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        issue(8);
        wait_idle();

        // Valid held for 7 cycles: accepts only at each completion.
        vi = 9;
        mode = vt[9].mode;
        cmd_level = vt[9].lvl;
        cmd_verify = vt[9].ver;
        w0 = wr_seen;
        cmd_valid = 1'b1;
        repeat (7) begin
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        wait_idle();
        check("held_accepts", wr_seen - w0, 32'd3);

        // Stray responses in IDLE must be ignored.
        mode = M_NORM;
        stray = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        stray = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        check("stray_ready", {31'd0, cmd_ready_o}, 32'd1);
        check("stray_flags", {30'd0, req_o, done_o}, 32'd0);
        issue(6);
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
